// File: rtl/aes_pkg.sv
// Shared AES constants: mode codes, key-length lookups, GF(2^8) doubling and the S-box table.
package aes_pkg;

  localparam logic [1:0] MODE_AES128 = 2'd0;
  localparam logic [1:0] MODE_AES192 = 2'd1;
  localparam logic [1:0] MODE_AES256 = 2'd2;

  function automatic logic [3:0] NK_OF(input logic [1:0] m);
    case (m)
      MODE_AES128: return 4'd4;
      MODE_AES192: return 4'd6;
      default:     return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] NR_OF(input logic [1:0] m);
    case (m)
      MODE_AES128: return 4'd10;
      MODE_AES192: return 4'd12;
      default:     return 4'd14;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel byte S-box lookups on one 32-bit word.
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  assign out_word = {SBOX[in_word[31:24]], SBOX[in_word[23:16]],
                     SBOX[in_word[15:8]],  SBOX[in_word[7:0]]};

endmodule

// File: rtl/round_key_gen.sv
// Streaming AES-128/192/256 round-key generator: an 8-word sliding window yields
// four freshly expanded words per Advance, so one round key is ready every cycle.
module round_key_gen
  import aes_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Load,
  input  logic [0:1]   mode,
  input  logic [0:255] Key,
  input  logic         Advance,
  output logic [0:127] RoundKey,
  output logic [3:0]   Round,
  output logic         KeyValid,
  output logic         LastKey
);

  logic [31:0] win_q [8];
  logic [31:0] win_d [8];
  logic [2:0]  jmod_q, jmod_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  nk_q, nk_d, nr_q, nr_d, round_d, jmod_wrap;
  logic        key_valid_d, step;
  logic [3:0]  is_rot, is_sub;
  logic [3:0][31:0] back;
  logic [31:0] sin0, sin1, sin2, sin3, sout0, sout1, sout2, sout3, nw0, nw1, nw2, nw3;

  function automatic logic [3:0] slot_pos(input logic [2:0] jm, input logic [3:0] off,
                                          input logic [3:0] nk);
    logic [3:0] s;
    s = 4'(jm) + off;
    if (s >= nk) s = s - nk;
    return s;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] bk, input logic [31:0] prev,
                                      input logic [31:0] sw, input logic rot,
                                      input logic sub, input logic [7:0] rc);
    logic [31:0] t;
    t = rot ? (sw ^ {rc, 24'h0}) : (sub ? sw : prev);
    return bk ^ t;
  endfunction

  // Per-slot position within the key period and the word Nk positions back.
  always_comb begin
    is_rot = '0;
    is_sub = '0;
    back   = '0;
    for (int k = 0; k < 4; k++) begin
      is_rot[k] = (slot_pos(jmod_q, 4'(k), nk_q) == 4'd0);
      is_sub[k] = (nk_q == 4'd8) && (slot_pos(jmod_q, 4'(k), nk_q) == 4'd4);
      back[k]   = win_q[3'(4'd8 + 4'(k) - nk_q)];
    end
  end

  // Four chained expansion stages; RotWord only feeds SubWord on the rcon slot.
  assign sin0 = is_rot[0] ? rot_word(win_q[7]) : win_q[7];
  sub_word u_sw0 (.in_word(sin0), .out_word(sout0));
  assign nw0  = mix(back[0], win_q[7], sout0, is_rot[0], is_sub[0], rcon_q);

  assign sin1 = is_rot[1] ? rot_word(nw0) : nw0;
  sub_word u_sw1 (.in_word(sin1), .out_word(sout1));
  assign nw1  = mix(back[1], nw0, sout1, is_rot[1], is_sub[1], rcon_q);

  assign sin2 = is_rot[2] ? rot_word(nw1) : nw1;
  sub_word u_sw2 (.in_word(sin2), .out_word(sout2));
  assign nw2  = mix(back[2], nw1, sout2, is_rot[2], is_sub[2], rcon_q);

  assign sin3 = is_rot[3] ? rot_word(nw2) : nw2;
  sub_word u_sw3 (.in_word(sin3), .out_word(sout3));
  assign nw3  = mix(back[3], nw2, sout3, is_rot[3], is_sub[3], rcon_q);

  assign step      = Advance && KeyValid && (Round < nr_q);
  assign jmod_wrap = slot_pos(jmod_q, 4'd4, nk_q);

  always_comb begin
    win_d       = win_q;
    jmod_d      = jmod_q;
    rcon_d      = rcon_q;
    round_d     = Round;
    nk_d        = nk_q;
    nr_d        = nr_q;
    key_valid_d = KeyValid;
    if (Load) begin
      nk_d = NK_OF(mode);
      nr_d = NR_OF(mode);
      for (int i = 0; i < 8; i++) win_d[i] = '0;
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nk_d) win_d[3'(4'd8 - nk_d + 4'(i))] = Key[32*i +: 32];
      end
      jmod_d      = '0;
      rcon_d      = 8'h01;
      round_d     = '0;
      key_valid_d = 1'b1;
    end else if (step) begin
      for (int i = 0; i < 4; i++) win_d[i] = win_q[i+4];
      win_d[4] = nw0;
      win_d[5] = nw1;
      win_d[6] = nw2;
      win_d[7] = nw3;
      jmod_d   = 3'(jmod_wrap);
      if (|is_rot) rcon_d = xtime(rcon_q);
      round_d  = Round + 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) win_q[i] <= '0;
      jmod_q   <= '0;
      rcon_q   <= 8'h01;
      nk_q     <= 4'd4;
      nr_q     <= 4'd10;
      Round    <= '0;
      KeyValid <= 1'b0;
      LastKey  <= 1'b0;
      RoundKey <= '0;
    end else begin
      win_q    <= win_d;
      jmod_q   <= jmod_d;
      rcon_q   <= rcon_d;
      nk_q     <= nk_d;
      nr_q     <= nr_d;
      Round    <= round_d;
      KeyValid <= key_valid_d;
      LastKey  <= key_valid_d && (round_d == nr_d);
      case (nk_d)
        4'd4:    RoundKey <= {win_d[4], win_d[5], win_d[6], win_d[7]};
        4'd6:    RoundKey <= {win_d[2], win_d[3], win_d[4], win_d[5]};
        default: RoundKey <= {win_d[0], win_d[1], win_d[2], win_d[3]};
      endcase
    end
  end

endmodule

// File: doc/round_key_gen.md
# round_key_gen

Streaming AES round-key generator for AES-128/192/256, sitting directly upstream of the `cipher` round datapath. It latches a cipher key, then presents round key 0 and advances to round key r+1 on each `Advance` pulse. `Advance` is driven in lockstep with the cipher's `Enable`, so `RoundKey` always holds the key for the round the cipher is about to compute. It generates 4 expanded words per cycle from a sliding 8-word window; no full key schedule is stored.

## Interface
- No parameters.
- `Clk` in 1: clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Load` in 1: latch `Key`/`mode`, restart at round 0.
- `mode` in 2 ([0:1]): 0 = AES-128, 1 = AES-192, 2 or 3 = AES-256 (same encoding as `cipher`).
- `Key` in 256 ([0:255]): left-aligned; AES-128 uses [0:127], AES-192 uses [0:191]; unused bits ignored.
- `Advance` in 1: step to next round key.
- `RoundKey` out 128 ([0:127]): current round key, word 0 in bits [0:31].
- `Round` out 4: index of the current round key (0..Nr).
- `KeyValid` out 1: `RoundKey` is meaningful.
- `LastKey` out 1: `Round == Nr`.

## Operation
- Nk/Nr: mode 0 → 4/10; mode 1 → 6/12; modes 2 and 3 → 8/14. Round keys: Nr+1 = 11/13/15.
- State: window `W[0..7]` of 32-bit words, write index `j`, `jmod` = j mod Nk, `rcon` byte, `Round`, latched Nk.
- Load: `W[8-Nk..7]` = key words 0..Nk-1. Lower window words = 0. Also `j`=Nk, `jmod`=0, `rcon`=0x01, `Round`=0, `KeyValid`=1.
- `RoundKey` = `W[8-Nk .. 11-Nk]` for all modes (positions 4..7 / 2..5 / 0..3).
- Advance step, when `KeyValid` and `Round < Nr`: compute w[j..j+3] chained in one cycle. For each k = 0..3, i = j+k:
  - temp = w[i-1]
  - if i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon_i, 24'h0}
  - else if Nk=8 and i mod 8 == 4: temp = SubWord(temp)
  - w[i] = w[i-Nk] ^ temp
- Rcon: at most one i mod Nk == 0 per step, using the current `rcon`. The register then advances via xtime (0x01,02,04,…,80,1B,36).
- After the step: `W` shifts left by 4 words with new words in `W[4..7]`, `j` += 4, `jmod` updated modulo Nk, `Round` += 1.
- Advance is ignored when `Round == Nr` (outputs hold) or when `KeyValid` = 0.
- Load together with Advance: Load wins.
- Load mid-sequence: restarts with the new key/mode and discards all state.
- `mode` and `Key` are sampled only on Load.

## Timing
- Reset values: `RoundKey`=0, `Round`=0, `KeyValid`=0, `LastKey`=0, `W`=0, `rcon`=0x01. Reset overrides Load/Advance.
- Load at edge k → `RoundKey` = key 0 and `KeyValid`=1 after edge k (1-cycle latency).
- Advance at edge k → key r+1 visible after edge k. One key per cycle at full rate; no bubbles.
- `LastKey` is registered and rises in the same cycle `Round` becomes Nr.
- Critical path: up to 4 chained word stages; at most one SubWord per step is on the path. Single-cycle requirement is decided.

## Structure
- Shared package `aes_pkg`:
  - mode codes
  - `NK_OF(mode)`, `NR_OF(mode)` constants
  - `xtime` function
  - S-box table, shared with `sub_bytes`
- Sub-module `sub_word` (4 byte S-boxes, 32-bit in/out, combinational). Instantiated 4×, one per word slot.
- Top-level holds window, counters, and the chaining logic; target 150–250 lines.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, Load, 10 Advances → round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `LastKey`=1. An 11th Advance holds all outputs.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → round 0 = 8e73b0f7da0e6452c810f32b809079e5; round 1 = 62f8ead2522c6b7bfe0c91f72402f5a5; `LastKey` at `Round`=12.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → round 1 = 1f352c073b6108d72d9810a30914dff4; round 2 = 9ba354118e6925afa51a8b5f2067fcde; `LastKey` at `Round`=14.
- Load asserted with Advance at `Round`=5 (AES-128) → next cycle `Round`=0, `RoundKey` = new key.
- Reset asserted mid-sequence, including with Load high → all outputs 0 next cycle; Advance while `KeyValid`=0 has no effect.
- Lockstep with `cipher` (mode 0, FIPS-197 plaintext 3243f6a8885a308d313198a2e0370734) → `Result` = 3925841d02dc09fbdc118597196a0b32 when `endCipher` is high.
